// File: rtl/spectrum_pkg.sv
// Shared types and constants for the image column loader.
//   WORD_W         : sample / memory word width
//   DEF_ROWS/COLS  : default frame geometry (banks x bank depth)
//   loader_state_t : column loader FSM states
//   col_vec_t      : one packed column at the default geometry
//   cnt_width()    : counter width for a modulus, never below 1 bit
package spectrum_pkg;

   localparam int WORD_W   = 32;
   localparam int DEF_ROWS = 4;
   localparam int DEF_COLS = 4;

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      WRITE,
      DONE
   } loader_state_t;

   typedef logic [DEF_ROWS-1:0][WORD_W-1:0] col_vec_t;

   function automatic int cnt_width(input int modulus);
      return (modulus > 1) ? $clog2(modulus) : 1;
   endfunction

endpackage

// File: rtl/column_loader_if.sv
// Sample stream, control and column-write bus of the column loader.
//   master : upstream feeder (drives start/abort/in_valid/in_data)
//   slave  : column loader (drives in_ready/we/write_data/addr_write/busy/done)
interface column_loader_if
   import spectrum_pkg::*;
#(
   parameter int IMG_ROWS = DEF_ROWS
);

   logic                             start;
   logic                             abort;
   logic                             in_valid;
   logic                             in_ready;
   logic [WORD_W-1:0]                in_data;
   logic                             we;
   logic [IMG_ROWS-1:0][WORD_W-1:0]  write_data;
   logic [WORD_W-1:0]                addr_write;
   logic                             busy;
   logic                             done;

   modport master (
      output start, abort, in_valid, in_data,
      input  in_ready, we, write_data, addr_write, busy, done
   );

   modport slave (
      input  start, abort, in_valid, in_data,
      output in_ready, we, write_data, addr_write, busy, done
   );

endinterface

// File: rtl/mod_counter.sv
// Modulo-MODULUS up-counter.
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : advance by one, wrapping to 0 after MODULUS-1
//   clr_i      : synchronous clear, wins over en_i
//   cnt_o      : current count
//   wrap_o     : count is at MODULUS-1 (next enabled step wraps)
module mod_counter
   import spectrum_pkg::*;
#(
   parameter  int MODULUS = 4,
   localparam int CW      = cnt_width(MODULUS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en_i,
   input  logic          clr_i,
   output logic [CW-1:0] cnt_o,
   output logic          wrap_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign wrap_o = (cnt_q == CW'(MODULUS - 1));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = wrap_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/column_loader.sv
// Packs a column-major sample stream into whole-column writes for the
// image column memory and flags the end of each frame.
//   clk, rst_l : clock, asynchronous active-low reset
//   bus        : column_loader_if.slave (stream in, control, column write out)
//
// state | meaning
// IDLE  | waiting for start, stream not accepted
// FILL  | accepting samples into write_data[row_idx]
// WRITE | one-cycle column write at col_idx
// DONE  | one-cycle done pulse after the last column
module column_loader
   import spectrum_pkg::*;
#(
   parameter int IMG_ROWS = DEF_ROWS,
   parameter int IMG_COLS = DEF_COLS
) (
   input  logic            clk,
   input  logic            rst_l,
   column_loader_if.slave  bus
);

   localparam int RW  = cnt_width(IMG_ROWS);
   localparam int CLW = cnt_width(IMG_COLS);

   loader_state_t                   state_q;
   logic                            we_q;
   logic                            done_q;
   logic                            busy_q;
   logic [IMG_ROWS-1:0][WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0]               addr_q;

   logic [RW-1:0]  row_idx;
   logic [CLW-1:0] col_idx;
   logic           row_last;
   logic           col_last;
   logic           abort_act;
   logic           xfer;
   logic           row_en;
   logic           row_clr;
   logic           col_en;
   logic           col_clr;

   // abort is only meaningful outside IDLE; an aborted cycle consumes nothing
   assign abort_act = bus.abort && (state_q != IDLE);
   assign xfer      = (state_q == FILL) && bus.in_valid && !abort_act;

   assign row_en  = xfer;
   assign row_clr = abort_act || (state_q == IDLE);
   // col_idx wraps to 0 on the last WRITE, so it is already clear in DONE
   assign col_en  = (state_q == WRITE) && !abort_act;
   assign col_clr = abort_act || (state_q == IDLE) || (state_q == DONE);

   mod_counter #(.MODULUS(IMG_ROWS)) u_row_cnt (
      .clk    (clk),
      .rst_n  (rst_l),
      .en_i   (row_en),
      .clr_i  (row_clr),
      .cnt_o  (row_idx),
      .wrap_o (row_last)
   );

   mod_counter #(.MODULUS(IMG_COLS)) u_col_cnt (
      .clk    (clk),
      .rst_n  (rst_l),
      .en_i   (col_en),
      .clr_i  (col_clr),
      .cnt_o  (col_idx),
      .wrap_o (col_last)
   );

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         wdata_q <= '0;
         addr_q  <= '0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         if (xfer) begin
            wdata_q[row_idx] <= bus.in_data;
         end
         if (abort_act) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (bus.start) begin
                     state_q <= FILL;
                     busy_q  <= 1'b1;
                  end
               end
               FILL: begin
                  if (xfer && row_last) begin
                     state_q <= WRITE;
                     we_q    <= 1'b1;
                     addr_q  <= WORD_W'(col_idx);
                  end
               end
               WRITE: begin
                  if (col_last) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= FILL;
                  end
               end
               DONE: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
               default: begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.in_ready   = (state_q == FILL);
   assign bus.we         = we_q;
   assign bus.done       = done_q;
   assign bus.busy       = busy_q;
   assign bus.write_data = wdata_q;
   assign bus.addr_write = addr_q;

endmodule

// File: doc/column_loader.md
Name: column_loader

Overview:
- Upstream feeder for the image column memory (IMG_ROWS banks × IMG_COLS words, 32-bit).
- Accepts a column-major stream of 32-bit samples over a valid/ready handshake and packs IMG_ROWS consecutive samples into one column vector.
- Issues a single-cycle whole-column write at the column index.
- Signals completion once all IMG_COLS columns of a frame are written.

Parameters:
- IMG_ROWS, 4, samples per column; equals the number of memory banks.
- IMG_COLS, 4, columns per frame; equals the depth of each bank.

Ports:
- clk  input  1  system clock
- rst_l  input  1  asynchronous active-low reset
- start  input  1  begin loading a frame; sampled only in IDLE
- abort  input  1  synchronous cancel; returns to IDLE without writing the partial column
- in_valid  input  1  in_data is valid
- in_ready  output  1  block accepts a sample this cycle
- in_data  input  32  sample; column-major order, row 0 first
- we  output  1  column write strobe to the memory
- write_data  output  IMG_ROWS×32  packed column; element r = row r
- addr_write  output  32  column index; zero-extended
- busy  output  1  high in any state other than IDLE
- done  output  1  one-cycle pulse after the last column write

Behaviour:
- One clock, clk. Reset is asynchronous, active-low on rst_l.
- Reset values: state IDLE; in_ready, we, busy, done = 0; write_data, addr_write, row and column counters = 0.
- All outputs are registered, except in_ready, which decodes from state only. in_ready never depends on in_valid.
- A transfer occurs when in_valid & in_ready are both high at a rising edge.
- States:
  - IDLE: in_ready=0. start=1 → FILL, with row_idx=0 and col_idx=0.
  - FILL: in_ready=1. Each transfer stores in_data into write_data[row_idx]. On the transfer with row_idx==IMG_ROWS-1 → WRITE and row_idx wraps to 0; otherwise row_idx++.
  - WRITE (one cycle): we=1, addr_write=col_idx, in_ready=0. If col_idx==IMG_COLS-1 → DONE; otherwise col_idx++ → FILL.
  - DONE (one cycle): done=1, busy=1. Next state IDLE, col_idx cleared.
- Latency: we asserts in the cycle immediately after the transfer that completes a column.
- Throughput: IMG_ROWS+1 cycles per column when in_valid is held high.
- write_data holds its value after a write. Element r is overwritten only by the next transfer at row r.
- in_valid low in FILL stalls: no counter or data changes.
- start while busy is ignored. in_valid in IDLE, WRITE or DONE is not consumed (in_ready=0).
- abort, in any non-IDLE state, takes priority over all other transitions:
  - next state IDLE; row_idx and col_idx cleared.
  - we and done are not asserted in the following cycle, even if the current cycle would have completed a column.
  - write_data is not cleared.
- abort in IDLE has no effect. abort together with start in IDLE → stays IDLE.
- rst_l low mid-frame: immediate return to reset values, no write issued.
- Counter widths: $clog2 of IMG_ROWS and IMG_COLS, each with a minimum of 1 bit. addr_write upper bits are always 0.

Decomposition:
- Shared package spectrum_pkg holds:
  - WORD_W=32
  - loader_state_t enum {IDLE, FILL, WRITE, DONE}
  - the column-vector typedef (logic [IMG_ROWS-1:0][WORD_W-1:0])
- One sub-module, mod_counter: parameterised modulus, enable, synchronous clear, asynchronous active-low reset, wrap flag output. Used twice, for row_idx and col_idx.

Test Plan (IMG_ROWS=4, IMG_COLS=4):
- Reset, then start, then 16 back-to-back samples 0x00..0x0F with in_valid held high:
  - we pulses at cycles 6, 11, 16, 21 after start.
  - addr_write = 0, 1, 2, 3 on those pulses.
  - write_data = {0x03,0x02,0x01,0x00}, {0x07,…,0x04}, etc. (element 0 = first sample).
  - done pulses exactly once, one cycle after the last we; busy falls the cycle after that.
- Samples with in_valid toggling 1/0 each cycle: same writes and data as above; no we while fewer than 4 samples are accepted for the column; in_ready stays 1 in FILL.
- abort asserted after 2 samples of column 1: no we for column 1, no done. Then start plus 16 fresh samples: writes start again at addr 0.
- start pulsed during FILL and again during WRITE: ignored; counters and write sequence unchanged vs. the first scenario.
- rst_l driven low asynchronously (between edges) mid-column 2: all outputs 0 immediately. After release, state is IDLE and in_ready=0 until start.
- in_valid=1 in IDLE with in_data=0xDEADBEEF: no transfer. write_data stays 0; the following start plus 16 samples produces the first-scenario results.
